// File: rtl/dcache_wb_if.sv
// CPU-side and memory-side signal bundle for the write-back data cache.
// slave is the cache's view; master is the CPU/memory environment's view.
interface dcache_wb_if #(
  parameter int DATABITS = 32,
  parameter int ADDRBITS = 32
);
  logic [ADDRBITS-1:0] dcache_addr;
  logic [DATABITS-1:0] dcache_in;
  logic [DATABITS-1:0] dcache_out;
  logic                dcache_valid;
  logic                dcache_rdreq;
  logic                dcache_wrreq;
  logic [1:0]          dcache_wordlen;
  logic                dcache_busy;
  logic [ADDRBITS-1:0] mem_addr;
  logic [DATABITS-1:0] mem_in;
  logic [DATABITS-1:0] mem_out;
  logic                mem_valid;
  logic [15:0]         mem_burstlen;
  logic                mem_rdreq;
  logic                mem_wrreq;

  modport slave (
    input  dcache_addr, dcache_in, dcache_rdreq, dcache_wrreq, dcache_wordlen,
           mem_out, mem_valid,
    output dcache_out, dcache_valid, dcache_busy,
           mem_addr, mem_in, mem_burstlen, mem_rdreq, mem_wrreq
  );

  modport master (
    output dcache_addr, dcache_in, dcache_rdreq, dcache_wrreq, dcache_wordlen,
           mem_out, mem_valid,
    input  dcache_out, dcache_valid, dcache_busy,
           mem_addr, mem_in, mem_burstlen, mem_rdreq, mem_wrreq
  );
endinterface

// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache with burst refill
// and burst write-back. Hits finish in one cycle with no memory traffic;
// a miss writes back a dirty victim, refills the whole line, then replays.
module dcache_wb #(
  parameter int DATABITS  = 32,
  parameter int ADDRBITS  = 32,
  parameter int LINEWORDS = 4,
  parameter int LINES     = 64
) (
  input logic        clk,
  input logic        reset_n,
  dcache_wb_if.slave bus
);
  localparam int WB = $clog2(LINEWORDS);
  localparam int IB = $clog2(LINES);
  localparam int TB = ADDRBITS - 2 - WB - IB;
  localparam int NW = LINES * LINEWORDS;

  typedef enum logic [2:0] {IDLE, WRBACK, FILLREQ, FILL, DONE} state_e;

  // Right-aligned, zero-extended load data from a stored word.
  function automatic logic [DATABITS-1:0] extract(input logic [DATABITS-1:0] w,
                                                  input logic [1:0] len,
                                                  input logic [1:0] off);
    logic [DATABITS-1:0] r;
    r = w;
    case (len)
      2'd0: case (off)
              2'd0:    r = {24'b0, w[7:0]};
              2'd1:    r = {24'b0, w[15:8]};
              2'd2:    r = {24'b0, w[23:16]};
              default: r = {24'b0, w[31:24]};
            endcase
      2'd1: r = off[1] ? {16'b0, w[31:16]} : {16'b0, w[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  // Byte-lane merge of right-aligned store data into a stored word.
  function automatic logic [DATABITS-1:0] merge(input logic [DATABITS-1:0] w,
                                                input logic [DATABITS-1:0] d,
                                                input logic [1:0] len,
                                                input logic [1:0] off);
    logic [DATABITS-1:0] r;
    r = w;
    case (len)
      2'd0: case (off)
              2'd0:    r[7:0]   = d[7:0];
              2'd1:    r[15:8]  = d[7:0];
              2'd2:    r[23:16] = d[7:0];
              default: r[31:24] = d[7:0];
            endcase
      2'd1: if (off[1]) r[31:16] = d[15:0];
            else        r[15:0]  = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  // Misaligned halfword/word addresses are silently rounded down.
  function automatic logic [ADDRBITS-1:0] align(input logic [ADDRBITS-1:0] a,
                                                input logic [1:0] len);
    logic [ADDRBITS-1:0] r;
    r = a;
    if (len == 2'd1)      r[0]   = 1'b0;
    else if (len != 2'd0) r[1:0] = 2'b00;
    return r;
  endfunction

  state_e              state_q, state_d;
  logic [WB-1:0]       cnt_q, cnt_d;
  logic [ADDRBITS-1:0] req_addr_q, req_addr_d;
  logic [DATABITS-1:0] req_data_q, req_data_d;
  logic [1:0]          req_len_q, req_len_d;
  logic                req_wr_q, req_wr_d;
  logic [DATABITS-1:0] out_q, out_d;
  logic                vld_q, vld_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic [LINES-1:0]    dirty_q, dirty_d;

  logic [DATABITS-1:0] data_arr [NW];
  logic [TB-1:0]       tag_arr  [LINES];

  logic                arr_we, tag_we;
  logic [IB+WB-1:0]    arr_widx;
  logic [DATABITS-1:0] arr_wdata;

  logic [ADDRBITS-1:0] mem_addr_c;
  logic [DATABITS-1:0] mem_in_c;
  logic                mem_rdreq_c, mem_wrreq_c;

  // Field split of the incoming CPU address and of the stored request.
  logic [ADDRBITS-1:0] c_addr;
  logic [IB-1:0]       c_idx, r_idx;
  logic [WB-1:0]       c_word, r_word;
  logic [TB-1:0]       c_tag, r_tag;
  logic                c_hit;
  logic [DATABITS-1:0] c_rdata, r_rdata, v_rdata;

  assign c_addr  = align(bus.dcache_addr, bus.dcache_wordlen);
  assign c_word  = c_addr[2 +: WB];
  assign c_idx   = c_addr[2+WB +: IB];
  assign c_tag   = c_addr[ADDRBITS-1 -: TB];
  assign r_word  = req_addr_q[2 +: WB];
  assign r_idx   = req_addr_q[2+WB +: IB];
  assign r_tag   = req_addr_q[ADDRBITS-1 -: TB];
  assign c_hit   = valid_q[c_idx] && (tag_arr[c_idx] == c_tag);
  assign c_rdata = data_arr[{c_idx, c_word}];
  assign r_rdata = data_arr[{r_idx, r_word}];
  assign v_rdata = data_arr[{r_idx, cnt_q}];

  // Next-state, hit handling, burst sequencing and memory-side outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    req_len_d   = req_len_q;
    req_wr_d    = req_wr_q;
    out_d       = out_q;
    vld_d       = 1'b0;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    arr_we      = 1'b0;
    arr_widx    = '0;
    arr_wdata   = '0;
    tag_we      = 1'b0;
    mem_addr_c  = '0;
    mem_in_c    = '0;
    mem_rdreq_c = 1'b0;
    mem_wrreq_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.dcache_rdreq || bus.dcache_wrreq) begin
          if (c_hit) begin
            // Store wins when both strobes are high.
            if (bus.dcache_wrreq) begin
              arr_we         = 1'b1;
              arr_widx       = {c_idx, c_word};
              arr_wdata      = merge(c_rdata, bus.dcache_in, bus.dcache_wordlen, c_addr[1:0]);
              dirty_d[c_idx] = 1'b1;
            end else begin
              out_d = extract(c_rdata, bus.dcache_wordlen, c_addr[1:0]);
              vld_d = 1'b1;
            end
          end else begin
            req_addr_d = c_addr;
            req_data_d = bus.dcache_in;
            req_len_d  = bus.dcache_wordlen;
            req_wr_d   = bus.dcache_wrreq;
            cnt_d      = '0;
            state_d    = (valid_q[c_idx] && dirty_q[c_idx]) ? WRBACK : FILLREQ;
          end
        end
      end
      WRBACK: begin
        mem_wrreq_c = 1'b1;
        mem_addr_c  = {tag_arr[r_idx], r_idx, cnt_q, 2'b00};
        mem_in_c    = v_rdata;
        cnt_d       = cnt_q + WB'(1);
        if (cnt_q == WB'(LINEWORDS-1)) state_d = FILLREQ;
      end
      FILLREQ: begin
        // The line is about to be overwritten, so it stops being valid now.
        mem_rdreq_c    = 1'b1;
        mem_addr_c     = {r_tag, r_idx, {WB{1'b0}}, 2'b00};
        valid_d[r_idx] = 1'b0;
        dirty_d[r_idx] = 1'b0;
        cnt_d          = '0;
        state_d        = FILL;
      end
      FILL: begin
        if (bus.mem_valid) begin
          arr_we    = 1'b1;
          arr_widx  = {r_idx, cnt_q};
          arr_wdata = bus.mem_out;
          cnt_d     = cnt_q + WB'(1);
          if (cnt_q == WB'(LINEWORDS-1)) begin
            tag_we         = 1'b1;
            valid_d[r_idx] = 1'b1;
            dirty_d[r_idx] = 1'b0;
            state_d        = DONE;
          end
        end
      end
      DONE: begin
        // Replay the parked request against the freshly filled line.
        if (req_wr_q) begin
          arr_we         = 1'b1;
          arr_widx       = {r_idx, r_word};
          arr_wdata      = merge(r_rdata, req_data_q, req_len_q, req_addr_q[1:0]);
          dirty_d[r_idx] = 1'b1;
        end else begin
          out_d = extract(r_rdata, req_len_q, req_addr_q[1:0]);
          vld_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, request latch, load-data register and line flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_addr_q <= '0;
      req_data_q <= '0;
      req_len_q  <= '0;
      req_wr_q   <= 1'b0;
      out_q      <= '0;
      vld_q      <= 1'b0;
      valid_q    <= '0;
      dirty_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      req_len_q  <= req_len_d;
      req_wr_q   <= req_wr_d;
      out_q      <= out_d;
      vld_q      <= vld_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
    end
  end

  // Data and tag storage; contents are meaningless until the valid bit says otherwise.
  always_ff @(posedge clk) begin
    if (arr_we) data_arr[arr_widx] <= arr_wdata;
    if (tag_we) tag_arr[r_idx]     <= r_tag;
  end

  assign bus.dcache_out   = out_q;
  assign bus.dcache_valid = vld_q;
  assign bus.dcache_busy  = (state_q != IDLE);
  assign bus.mem_addr     = mem_addr_c;
  assign bus.mem_in       = mem_in_c;
  assign bus.mem_rdreq    = mem_rdreq_c;
  assign bus.mem_wrreq    = mem_wrreq_c;
  assign bus.mem_burstlen = 16'(LINEWORDS);
endmodule

// File: tb/tb_dcache_wb.sv
// Bench for dcache_wb: directed scenarios plus a randomized run against an
// "ideal flat memory" view and a line-occupancy model of a direct-mapped cache.
module tb_dcache_wb;
  localparam int LW    = 4;
  localparam int LINES = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  dcache_wb_if #(.DATABITS(32), .ADDRBITS(32)) bif();
  dcache_wb #(.DATABITS(32), .ADDRBITS(32), .LINEWORDS(LW), .LINES(LINES))
    dut (.clk(clk), .reset_n(reset_n), .bus(bif));

  int vec = 0;
  int err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Backing memory seen by the cache, and the value the CPU should observe.
  logic [31:0] mem   [logic [31:0]];
  logic [31:0] ideal [logic [31:0]];
  bit          mvalid [LINES];
  bit          mdirty [LINES];
  int unsigned mtag   [LINES];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a * 32'h9E3779B1 + 32'h01234567;
  endfunction
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction
  function automatic logic [31:0] ideal_rd(input logic [31:0] a);
    return ideal.exists(a) ? ideal[a] : init_val(a);
  endfunction

  // Memory responder / monitor, all on the falling edge.
  int          pending = 0, burst_k = 0, gap_ctr = 0, gap_mode = -1;
  int          rd_cnt = 0, wr_cnt = 0;
  bit          noise_en = 1'b0;
  logic [31:0] burst_base = '0, last_rd_addr = '0;
  logic [15:0] last_blen = '0;
  logic [31:0] wq_addr [$];
  logic [31:0] wq_data [$];

  always @(negedge clk) begin
    if (!reset_n) begin
      pending       = 0;
      bif.mem_valid = 1'b0;
    end else begin
      if (pending > 0) begin
        if (gap_ctr == 0) begin
          bif.mem_valid = 1'b1;
          bif.mem_out   = mem_rd(burst_base + 32'(4 * burst_k));
          burst_k++;
          pending--;
          gap_ctr = (gap_mode < 0) ? int'($urandom_range(0, 2)) : gap_mode;
        end else begin
          bif.mem_valid = 1'b0;
          bif.mem_out   = $urandom;
          gap_ctr--;
        end
      end else begin
        bif.mem_valid = noise_en && ($urandom_range(0, 3) == 0);
        bif.mem_out   = $urandom;
      end
      if (bif.mem_wrreq) begin
        mem[bif.mem_addr] = bif.mem_in;
        wq_addr.push_back(bif.mem_addr);
        wq_data.push_back(bif.mem_in);
        wr_cnt++;
      end
      if (bif.mem_rdreq) begin
        rd_cnt++;
        last_rd_addr = bif.mem_addr;
        last_blen    = bif.mem_burstlen;
        burst_base   = bif.mem_addr;
        burst_k      = 0;
        pending      = LW;
        gap_ctr      = (gap_mode < 0) ? int'($urandom_range(0, 2)) : 0;
      end
    end
  end

  // Model expectations for one request.
  bit          e_hit, e_wb;
  logic [31:0] e_base, e_vbase, e_data;
  logic [31:0] e_wbd [LW];

  task automatic model_req(input logic [31:0] a_in, input logic [1:0] len,
                           input bit wr, input logic [31:0] d);
    logic [31:0] a, w, m;
    int unsigned idx, tag, sh;
    a = a_in;
    if (len == 2'd1) a[0] = 1'b0;
    else if (len != 2'd0) a[1:0] = 2'b00;
    idx     = (a / (LW * 4)) % LINES;
    tag     = a / (LW * 4 * LINES);
    e_base  = (a / (LW * 4)) * (LW * 4);
    e_hit   = mvalid[idx] && (mtag[idx] == tag);
    e_wb    = !e_hit && mvalid[idx] && mdirty[idx];
    e_vbase = 32'((mtag[idx] * LINES + idx) * LW * 4);
    for (int k = 0; k < LW; k++) e_wbd[k] = ideal_rd(e_vbase + 32'(4 * k));
    if (!e_hit) begin
      mvalid[idx] = 1'b1;
      mtag[idx]   = tag;
      mdirty[idx] = 1'b0;
    end
    m  = (len == 2'd0) ? 32'hFF : (len == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    sh = 8 * a[1:0];
    w  = ideal_rd({a[31:2], 2'b00});
    if (wr) begin
      ideal[{a[31:2], 2'b00}] = (w & ~(m << sh)) | ((d & m) << sh);
      mdirty[idx] = 1'b1;
      e_data = '0;
    end else begin
      e_data = (w >> sh) & m;
    end
  endtask

  task automatic model_reset();
    ideal = mem;
    for (int i = 0; i < LINES; i++) begin
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
    end
  endtask

  // CPU driver: issues one request at the current falling edge and collects observations.
  logic        o_busy1;
  int          o_vcnt, o_rd, o_wr, o_wq0, o_left;
  bit          o_tmo;
  logic [31:0] o_data;

  task automatic do_req(input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] len, input bit rd, input bit wr);
    int rd0, wr0;
    rd0   = rd_cnt;
    wr0   = wr_cnt;
    o_wq0 = wq_addr.size();
    bif.dcache_addr = a; bif.dcache_in = d; bif.dcache_wordlen = len;
    bif.dcache_rdreq = rd; bif.dcache_wrreq = wr;
    @(negedge clk);
    o_busy1 = bif.dcache_busy;
    o_vcnt  = int'(bif.dcache_valid);
    o_data  = bif.dcache_out;
    o_tmo   = 1'b0;
    bif.dcache_rdreq = 1'b0; bif.dcache_wrreq = 1'b0;
    if (o_busy1) begin
      o_tmo = 1'b1;
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        if (bif.dcache_valid) begin o_vcnt++; o_data = bif.dcache_out; end
        if (!bif.dcache_busy) begin o_tmo = 1'b0; break; end
        if (noise_en) begin
          bif.dcache_addr = $urandom; bif.dcache_in = $urandom;
          bif.dcache_rdreq = 1'($urandom_range(0, 1));
          bif.dcache_wrreq = 1'($urandom_range(0, 1));
        end
      end
      bif.dcache_rdreq = 1'b0; bif.dcache_wrreq = 1'b0;
    end
    #1;
    o_rd   = rd_cnt - rd0;
    o_wr   = wr_cnt - wr0;
    o_left = pending;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bif.dcache_addr = '0; bif.dcache_in = '0; bif.dcache_wordlen = '0;
    bif.dcache_rdreq = 1'b0; bif.dcache_wrreq = 1'b0;
    bif.mem_out = '0; bif.mem_valid = 1'b0;
    #2;
    vec++; if ({bif.dcache_out, bif.dcache_valid, bif.dcache_busy} !== 34'b0) begin
      err++; $display("FAIL reset_cpu_side: got out=%h v=%b busy=%b want 0", bif.dcache_out, bif.dcache_valid, bif.dcache_busy); end
    vec++; if ({bif.mem_addr, bif.mem_in, bif.mem_rdreq, bif.mem_wrreq} !== 66'b0) begin
      err++; $display("FAIL reset_mem_side: got addr=%h in=%h rd=%b wr=%b want 0", bif.mem_addr, bif.mem_in, bif.mem_rdreq, bif.mem_wrreq); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    @(negedge clk); #1;
  endtask

  task automatic test_load_miss_hit();
    mem[32'h80] = 32'h11; mem[32'h84] = 32'h22; mem[32'h88] = 32'h33; mem[32'h8C] = 32'h44;
    ideal = mem;
    model_req(32'h80, 2'd2, 1'b0, '0);
    do_req(32'h80, '0, 2'd2, 1'b1, 1'b0);
    vec++; if (o_busy1 !== 1'b1) begin err++; $display("FAIL miss_busy: got %b want 1", o_busy1); end
    vec++; if (o_rd !== 1 || last_rd_addr !== 32'h80) begin
      err++; $display("FAIL miss_rdreq: got n=%0d addr=%h want 1 @00000080", o_rd, last_rd_addr); end
    vec++; if (last_blen !== 16'(LW)) begin err++; $display("FAIL burstlen: got %0d want %0d", last_blen, LW); end
    vec++; if (o_vcnt !== 1 || o_data !== 32'h11 || o_tmo) begin
      err++; $display("FAIL miss_load: got n=%0d d=%h tmo=%b want 1 00000011", o_vcnt, o_data, o_tmo); end
    model_req(32'h8C, 2'd2, 1'b0, '0);
    do_req(32'h8C, '0, 2'd2, 1'b1, 1'b0);
    vec++; if (o_busy1 !== 1'b0 || o_rd !== 0 || o_vcnt !== 1 || o_data !== 32'h44) begin
      err++; $display("FAIL hit_load: got busy=%b rd=%0d n=%0d d=%h want 0 0 1 00000044", o_busy1, o_rd, o_vcnt, o_data); end
  endtask

  task automatic test_store_merge();
    int wr_tot;
    logic [31:0] av [3];
    logic [31:0] dv [3];
    logic [1:0]  lv [3];
    av = '{32'h80, 32'h81, 32'h82};
    dv = '{32'h0FFF0001, 32'hAB, 32'hCDEF};
    lv = '{2'd2, 2'd0, 2'd1};
    wr_tot = 0;
    for (int i = 0; i < 3; i++) begin
      model_req(av[i], lv[i], 1'b1, dv[i]);
      do_req(av[i], dv[i], lv[i], 1'b0, 1'b1);
      wr_tot += o_wr;
      vec++; if (o_vcnt !== 0) begin err++; $display("FAIL store_no_valid[%0d]: got %0d want 0", i, o_vcnt); end
    end
    model_req(32'h80, 2'd2, 1'b0, '0);
    do_req(32'h80, '0, 2'd2, 1'b1, 1'b0);
    vec++; if (o_data !== 32'hCDEFAB01 || o_vcnt !== 1) begin
      err++; $display("FAIL merge_load: got n=%0d d=%h want 1 cdefab01", o_vcnt, o_data); end
    vec++; if (wr_tot + o_wr !== 0) begin err++; $display("FAIL merge_no_wb: got %0d want 0", wr_tot + o_wr); end
  endtask

  task automatic test_dirty_evict();
    model_req(32'h480, 2'd2, 1'b0, '0);
    do_req(32'h480, '0, 2'd2, 1'b1, 1'b0);
    vec++; if (o_wr !== LW) begin err++; $display("FAIL evict_wr_cnt: got %0d want %0d", o_wr, LW); end
    if (o_wr == LW)
      for (int k = 0; k < LW; k++) begin
        vec++; if (wq_addr[o_wq0+k] !== 32'h80 + 32'(4*k) || wq_data[o_wq0+k] !== e_wbd[k]) begin
          err++; $display("FAIL evict_word[%0d]: got %h@%h want %h@%h", k, wq_data[o_wq0+k], wq_addr[o_wq0+k], e_wbd[k], 32'h80 + 32'(4*k)); end
      end
    vec++; if (o_rd !== 1 || last_rd_addr !== 32'h480) begin
      err++; $display("FAIL evict_rdreq: got n=%0d addr=%h want 1 @00000480", o_rd, last_rd_addr); end
    vec++; if (mem_rd(32'h80) !== 32'hCDEFAB01) begin
      err++; $display("FAIL evict_mem: got %h want cdefab01", mem_rd(32'h80)); end
    vec++; if (o_data !== e_data) begin err++; $display("FAIL evict_load: got %h want %h", o_data, e_data); end
  endtask

  task automatic test_clean_evict();
    model_req(32'h480, 2'd2, 1'b0, '0);
    do_req(32'h480, '0, 2'd2, 1'b1, 1'b0);
    vec++; if (o_rd !== 0 || o_wr !== 0) begin err++; $display("FAIL clean_hit: got rd=%0d wr=%0d want 0 0", o_rd, o_wr); end
    model_req(32'h880, 2'd2, 1'b0, '0);
    do_req(32'h880, '0, 2'd2, 1'b1, 1'b0);
    vec++; if (o_rd !== 1 || o_wr !== 0 || last_rd_addr !== 32'h880) begin
      err++; $display("FAIL clean_evict: got rd=%0d wr=%0d addr=%h want 1 0 @00000880", o_rd, o_wr, last_rd_addr); end
    vec++; if (o_data !== e_data) begin err++; $display("FAIL clean_load: got %h want %h", o_data, e_data); end
  endtask

  task automatic test_fill_gaps();
    gap_mode = 2;
    model_req(32'hC86, 2'd1, 1'b0, '0);
    do_req(32'hC86, '0, 2'd1, 1'b1, 1'b0);
    vec++; if (o_vcnt !== 1 || o_data !== e_data || o_left !== 0 || o_tmo) begin
      err++; $display("FAIL gap_fill: got n=%0d d=%h left=%0d want 1 %h 0", o_vcnt, o_data, o_left, e_data); end
    gap_mode = -1;
  endtask

  task automatic test_reset_mid_fill();
    int n;
    gap_mode = 0;
    bif.dcache_addr = 32'h1000; bif.dcache_wordlen = 2'd2;
    bif.dcache_rdreq = 1'b1; bif.dcache_wrreq = 1'b0;
    @(negedge clk);
    bif.dcache_rdreq = 1'b0;
    n = 0;
    while (!(pending > 0 && burst_k == 2) && n < 50) begin @(negedge clk); #1; n++; end
    vec++; if (n >= 50) begin err++; $display("FAIL midfill_reach: got timeout want fill word 2"); end
    #2 reset_n = 1'b0;
    #1;
    vec++; if ({bif.dcache_out, bif.dcache_valid, bif.dcache_busy, bif.mem_addr, bif.mem_in,
                bif.mem_rdreq, bif.mem_wrreq} !== 100'b0) begin
      err++; $display("FAIL midfill_reset_out: got busy=%b addr=%h rd=%b want all 0", bif.dcache_busy, bif.mem_addr, bif.mem_rdreq); end
    @(negedge clk); #1;
    reset_n = 1'b1;
    model_reset();
    gap_mode = -1;
    @(negedge clk); #1;
    model_req(32'h1000, 2'd2, 1'b0, '0);
    do_req(32'h1000, '0, 2'd2, 1'b1, 1'b0);
    vec++; if (o_rd !== 1 || o_data !== e_data || o_vcnt !== 1) begin
      err++; $display("FAIL midfill_refill: got rd=%0d d=%h want 1 %h", o_rd, o_data, e_data); end
  endtask

  task automatic test_back_to_back();
    int c0;
    model_req(32'h2000, 2'd2, 1'b0, '0);
    do_req(32'h2000, '0, 2'd2, 1'b1, 1'b0);
    c0 = cyc;
    for (int k = 0; k < 4; k++) begin
      model_req(32'h2000 + 32'(4*((k+1)%4)), 2'd0, 1'b0, '0);
      do_req(32'h2000 + 32'(4*((k+1)%4)), '0, 2'd0, 1'b1, 1'b0);
      vec++; if (o_vcnt !== 1 || o_data !== e_data || o_busy1 !== 1'b0) begin
        err++; $display("FAIL b2b_hit[%0d]: got n=%0d d=%h want 1 %h", k, o_vcnt, o_data, e_data); end
    end
    vec++; if (cyc - c0 !== 4) begin err++; $display("FAIL b2b_rate: got %0d cycles want 4", cyc - c0); end
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic [1:0]  len;
    bit          rd, wr;
    int          op;
    noise_en = 1'b1;
    for (int n = 0; n < 250; n++) begin
      a   = 32'($urandom_range(0, 3) * 32'h400 + $urandom_range(0, 3) * 16 + $urandom_range(0, 15));
      d   = $urandom;
      len = 2'($urandom_range(0, 3));
      op  = $urandom_range(0, 3);
      rd  = (op != 2);
      wr  = (op >= 2);
      model_req(a, len, wr, d);
      do_req(a, d, len, rd, wr);
      vec++; if (o_busy1 !== !e_hit || o_tmo) begin
        err++; $display("FAIL rand_busy n=%0d: got %b tmo=%b want %b", n, o_busy1, o_tmo, !e_hit); end
      vec++; if (o_rd !== (e_hit ? 0 : 1) || (!e_hit && last_rd_addr !== e_base)) begin
        err++; $display("FAIL rand_rdreq n=%0d: got %0d @%h want %0d @%h", n, o_rd, last_rd_addr, !e_hit, e_base); end
      vec++; if (o_wr !== (e_wb ? LW : 0)) begin
        err++; $display("FAIL rand_wbcnt n=%0d: got %0d want %0d", n, o_wr, e_wb ? LW : 0); end
      if (e_wb && o_wr == LW)
        for (int k = 0; k < LW; k++) begin
          vec++; if (wq_addr[o_wq0+k] !== e_vbase + 32'(4*k) || wq_data[o_wq0+k] !== e_wbd[k]) begin
            err++; $display("FAIL rand_wb n=%0d k=%0d: got %h@%h want %h@%h", n, k, wq_data[o_wq0+k], wq_addr[o_wq0+k], e_wbd[k], e_vbase + 32'(4*k)); end
        end
      vec++; if (o_vcnt !== (wr ? 0 : 1) || (!wr && o_data !== e_data)) begin
        err++; $display("FAIL rand_data n=%0d: got n=%0d d=%h want %0d %h", n, o_vcnt, o_data, wr ? 0 : 1, e_data); end
    end
    noise_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_miss_hit();
    test_store_merge();
    test_dirty_evict();
    test_clean_evict();
    test_fill_gaps();
    test_reset_mid_fill();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/dcache_wb.md
Name: dcache_wb

Overview:
- Parametrised direct-mapped, write-back, write-allocate data cache between the CPU load/store unit and the big memory.
- Next generation of the single-word dcache: configurable line count and words per line, burst refill and burst write-back, dirty tracking, and byte/halfword/word merging.
- Hits complete without memory traffic; misses evict a dirty victim line, then refill the whole line.

Parameters:
- DATABITS, 32, CPU and memory word width; fixed at 32 because of the byte lanes.
- ADDRBITS, 32, byte address width.
- LINEWORDS, 4, words per line; power of 2, range 2..16.
- LINES, 64, number of lines; power of 2, range 2..1024.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- dcache_addr  in  ADDRBITS  CPU byte address.
- dcache_in  in  DATABITS  store data, right-aligned.
- dcache_out  out  DATABITS  load data, right-aligned and zero-extended.
- dcache_valid  out  1  one-cycle pulse: dcache_out is valid.
- dcache_rdreq  in  1  load request.
- dcache_wrreq  in  1  store request.
- dcache_wordlen  in  2  access size: 0=byte, 1=halfword, 2 or 3=word.
- dcache_busy  out  1  cache is servicing a miss; requests are ignored.
- mem_addr  out  ADDRBITS  memory byte address, always word-aligned.
- mem_in  out  DATABITS  write-back data to memory.
- mem_out  in  DATABITS  refill data from memory.
- mem_valid  in  1  mem_out holds the next refill word.
- mem_burstlen  out  16  word count of the current burst, equal to LINEWORDS.
- mem_rdreq  out  1  one-cycle refill burst start.
- mem_wrreq  out  1  write-back word strobe.

Behaviour:
- Address split:
  - offset = addr[1:0]
  - word = next log2(LINEWORDS) bits
  - index = next log2(LINES) bits
  - tag = the remaining upper bits
- Storage:
  - Data array of LINES*LINEWORDS words.
  - Tag array.
  - Per-line valid and dirty flops.
  - Valid and dirty bits clear asynchronously on reset_n=0; data and tag arrays are not reset.
- Reset values: dcache_out=0, dcache_valid=0, dcache_busy=0, mem_rdreq=0, mem_wrreq=0, mem_addr=0, mem_in=0; state=IDLE.
- Request sampling:
  - Requests are sampled at a rising edge in IDLE only; any request while busy=1 is ignored, and the CPU holds it until busy falls.
  - If rdreq and wrreq are both high, the store is performed and no load is performed.
- Alignment: halfword accesses force addr[0]=0; word accesses force addr[1:0]=0; no exception is raised.
- Read hit: dcache_out is registered and dcache_valid pulses 1 cycle after the sampling edge; busy stays 0. Back-to-back hits sustain one per cycle.
- Byte extraction: lane = addr[1:0]; a byte read returns {24'b0, byte}, a halfword read returns {16'b0, half}.
- Write hit: byte-lane merge into the stored word in the same cycle; the line's dirty bit sets; no dcache_valid pulse.
- Miss: busy rises 1 cycle after the sampling edge. The FSM stores the request (address, data, wordlen, read/write) internally.
- FSM states:
  - IDLE -> WRBACK on a miss with the victim line valid and dirty.
  - IDLE -> FILLREQ on a miss with the victim clean or invalid.
  - WRBACK: mem_wrreq=1 for LINEWORDS consecutive cycles. mem_addr = {victim tag, index, word counter, 2'b00}, incrementing by 4; mem_in = victim word. Memory accepts one word per cycle with no backpressure. -> FILLREQ.
  - FILLREQ: one cycle with mem_rdreq=1, mem_addr = line base of the requested address, mem_burstlen=LINEWORDS. -> FILL.
  - FILL: each mem_valid writes mem_out into the word-counter slot. Gaps between mem_valid cycles are allowed. After word LINEWORDS-1: write the tag, set valid, clear dirty. -> DONE.
  - DONE: replay the stored request as a hit. For a load: dcache_valid=1 with the data. For a store: merge and set dirty. busy=0 from the following cycle. -> IDLE.
- Refill order: always words 0..LINEWORDS-1; there is no critical-word-first.
- Counters: the word counter wraps to 0 at the end of each burst.
- mem_valid outside FILL is ignored.
- Reset asserted mid-burst: immediate return to IDLE with all outputs at reset values. Dirty data in flight is discarded, and a partially filled line stays invalid.

Test Plan:
- Reset, then load 0x80 word with memory preloaded 0x80..0x8C = 11,22,33,44:
  - busy=1, then one mem_rdreq at addr 0x80 with burstlen=4.
  - After the fill, dcache_out=0x00000011 with a one-cycle valid.
  - A following load of 0x8C hits: valid 1 cycle later with 0x00000044, no mem_rdreq.
- Store word 0x0FFF0001 to 0x80 (miss then hit), then store byte 0xAB to 0x81 and halfword 0xCDEF to 0x82:
  - Loading 0x80 returns 0xCDEFAB01.
  - No mem_wrreq yet.
- Dirty eviction, LINES=64, LINEWORDS=4:
  - Line 0x80 is dirty; load 0x80+0x400 (same index, new tag).
  - Expect 4 mem_wrreq cycles at 0x80..0x8C carrying the line data, then mem_rdreq at 0x480.
  - Memory now holds 0xCDEFAB01 at 0x80.
- Clean eviction: load 0x480 then 0x880 -> no mem_wrreq, only mem_rdreq.
- Refill with mem_valid gaps (1 cycle on, 2 off) -> correct data; busy stays high until DONE.
- reset_n pulsed low during FILL word 2:
  - Outputs return to reset values immediately.
  - A subsequent load to the same address misses and refills.
